// File: rtl/spi_led_frame_arbiter_pkg.sv
// Shared types and constants for the round-robin SPI LED frame arbiter.
package spi_led_pkg;

  localparam int unsigned FRAME_BITS = 8;
  localparam logic        SEL_RED    = 1'b0;
  localparam logic        SEL_BLUE   = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftHi,
    StShiftLo,
    StHold,
    StGap
  } state_e;

  typedef enum logic {
    GNT_RED  = 1'b0,
    GNT_BLUE = 1'b1
  } grant_e;

endpackage

// File: rtl/spi_led_frame_arbiter_if.sv
// Requester-side handshake bundle: two level request channels plus busy.
interface spi_led_frame_arbiter_if;

  logic       red_req;
  logic [6:0] red_data;
  logic       red_ack;
  logic       blue_req;
  logic [6:0] blue_data;
  logic       blue_ack;
  logic       busy;

  // Requester side
  modport master (
    output red_req, red_data, blue_req, blue_data,
    input  red_ack, blue_ack, busy
  );

  // Arbiter side
  modport slave (
    input  red_req, red_data, blue_req, blue_data,
    output red_ack, blue_ack, busy
  );

endinterface

// File: rtl/spi_led_frame_arbiter_sclk_tick.sv
// Half-period timer: one-cycle tick every CLK_DIV clocks, realigned on restart.
module spi_sclk_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_led_frame_arbiter.sv
// Round-robin arbiter serialising red/blue LED requests into 8-bit SPI mode-0 frames.
// Optional SDO readback capture is enabled by defining SPI_LED_READBACK_EN.
module spi_led_frame_arbiter
  import spi_led_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_led_frame_arbiter_if.slave bus,
  output logic                   CS,
  output logic                   SCLK,
  output logic                   SDI,
  input  logic                   SDO
`ifdef SPI_LED_READBACK_EN
  ,
  output logic [7:0]             rx_data,
  output logic                   rx_valid
`endif
);

  localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GapW-1:0] GapMax  = GapW'(CS_GAP - 1);
  localparam logic [3:0]      LastBit = 4'(FRAME_BITS);

  state_e                  state_q, state_d;
  grant_e                  last_q, grant_sel;
  logic                    grant_valid;
  logic                    tick;
  logic                    gap_done;
  logic                    ack_pulse;
  logic                    cs_active;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [3:0]              bit_cnt_q;
  logic [GapW-1:0]         gap_cnt_q;

  assign grant_valid = bus.red_req | bus.blue_req;
  assign gap_done    = (gap_cnt_q == GapMax);

  // On a tie the channel that did not win last time gets the link.
  always_comb begin
    grant_sel = GNT_RED;
    if (bus.red_req && bus.blue_req) begin
      grant_sel = (last_q == GNT_BLUE) ? GNT_RED : GNT_BLUE;
    end else if (bus.blue_req) begin
      grant_sel = GNT_BLUE;
    end
  end

  spi_sclk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state_q == StIdle && grant_valid),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (grant_valid) state_d = StSetup;
      StSetup:   if (tick) state_d = StShiftHi;
      StShiftHi: if (tick) state_d = StShiftLo;
      StShiftLo: if (tick) state_d = (bit_cnt_q == LastBit) ? StHold : StShiftHi;
      StHold:    if (tick) state_d = StGap;
      StGap:     if (gap_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      last_q    <= GNT_BLUE;
    end else begin
      if (state_q == StIdle && grant_valid) begin
        shift_q   <= (grant_sel == GNT_BLUE) ? {bus.blue_data, SEL_BLUE}
                                             : {bus.red_data, SEL_RED};
        last_q    <= grant_sel;
        bit_cnt_q <= '0;
      end else if (state_q == StShiftHi && tick) begin
        shift_q   <= shift_q >> 1;
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (state_q == StHold) begin
        gap_cnt_q <= '0;
      end else if (state_q == StGap && !gap_done) begin
        gap_cnt_q <= gap_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    cs_active    = (state_q == StSetup) || (state_q == StShiftHi) ||
                   (state_q == StShiftLo) || (state_q == StHold);
    CS           = ~cs_active;
    SCLK         = (state_q == StShiftHi);
    SDI          = cs_active & shift_q[0];
    bus.busy     = (state_q != StIdle);
    ack_pulse    = (state_q == StGap) && (gap_cnt_q == '0);
    bus.red_ack  = ack_pulse && (last_q == GNT_RED);
    bus.blue_ack = ack_pulse && (last_q == GNT_BLUE);
  end

`ifdef SPI_LED_READBACK_EN
  logic [7:0] rx_q;

  // SDO is captured on the clk edge that raises SCLK, LSB arriving first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q <= '0;
    end else if (state_d == StShiftHi && state_q != StShiftHi) begin
      rx_q <= {SDO, rx_q[7:1]};
    end
  end

  assign rx_data  = rx_q;
  assign rx_valid = ack_pulse;
`else
  logic unused_sdo;
  assign unused_sdo = SDO;
`endif

endmodule

// File: doc/spi_led_frame_arbiter.md
Name: spi_led_frame_arbiter

Overview:
- SPI master controller that shares one SPI link to the LED slave between two requesters: red channel and blue channel.
- Arbitrates round-robin between them and serialises each granted request into one 8-bit frame.
- Frame bit 0 is the select bit (0 = red, 1 = blue). Bits 1..7 are the LED pattern, LSB first.
- Sits between on-chip LED control logic and the slave's CS/SCLK/SDI/SDO pins.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range ≥2.
- CS_GAP, 8: clk cycles CS is held high between frames; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- red_req  in  1  red channel request; level, held until red_ack
- red_data  in  7  red LED pattern; must be stable while red_req=1
- red_ack  out  1  one-cycle pulse when the red frame completes
- blue_req  in  1  blue channel request; level, held until blue_ack
- blue_data  in  7  blue LED pattern; must be stable while blue_req=1
- blue_ack  out  1  one-cycle pulse when the blue frame completes
- busy  out  1  high from grant until the end of the CS gap
- CS  out  1  slave chip select, active low
- SCLK  out  1  serial clock, idle low (SPI mode 0)
- SDI  out  1  master-to-slave serial data
- SDO  in  1  slave-to-master serial data; used only with the optional feature

Behaviour:
- Reset (asynchronous, any state): CS=1, SCLK=0, SDI=0, red_ack=0, blue_ack=0, busy=0, FSM=IDLE, bit counter=0, last_grant=BLUE. Because last_grant resets to BLUE, red wins the first tie.
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP.
- IDLE:
  - If either req=1, grant one requester:
    - Both requesting: grant the one not equal to last_grant.
    - Only one requesting: grant that one.
  - On grant, latch shift_reg = {data[6:0], sel}, update last_grant, go to SETUP.
  - From the next cycle: busy=1, CS=0, SDI=shift_reg[0].
- SETUP: hold CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: SCLK=1 for CLK_DIV cycles; the slave samples SDI on the rising edge. Then go to SHIFT_LO.
- SHIFT_LO:
  - SCLK=0 for CLK_DIV cycles.
  - On entry: shift_reg shifts right, SDI = new shift_reg[0], bit counter increments.
  - After 8 bits go to HOLD; otherwise go to SHIFT_HI.
- HOLD: CS stays 0, SCLK=0 for CLK_DIV cycles, then go to GAP.
- GAP:
  - On entry: CS=1, SDI=0, and the granted channel's ack pulses for exactly one cycle.
  - Stay CS_GAP cycles, then go to IDLE with busy=0.
- Timing with defaults: CS low for 4+64+4 = 72 cycles. Grant to IDLE is 80 cycles. Arbitration for the next frame happens in the IDLE cycle.
- Counters: half-period counter is $clog2(CLK_DIV) bits and wraps at CLK_DIV-1. Bit counter is 4 bits, 0..8.
- req dropped mid-frame: the frame still completes and ack still pulses. Data is latched at grant, so later changes to data have no effect on the frame in flight.
- req held after ack: treated as a new request. With both channels continuously requesting, grants strictly alternate.
- Reset asserted mid-frame: CS returns high immediately (asynchronous) and the frame is aborted with no ack.
- Back-to-back requests: there is no IDLE bypass; the minimum spacing between frames is CS_GAP+1 cycles.

Optional Feature:
- Macro SPI_LED_READBACK_EN.
- Defined:
  - Adds outputs rx_data[7:0] (reset 0) and rx_valid (reset 0).
  - SDO is sampled on each SCLK rising edge and shifted in LSB first.
  - rx_valid pulses in the same cycle as ack, with rx_data holding the 8 captured bits.
- Undefined: the ports are absent and SDO is ignored.

Decomposition:
- Package spi_led_pkg holds:
  - state enum typedef
  - FRAME_BITS=8, SEL_RED=1'b0, SEL_BLUE=1'b1
  - grant typedef {GNT_RED, GNT_BLUE}
- Sub-module spi_sclk_tick: half-period counter producing a one-cycle tick every CLK_DIV cycles, restarted on grant.

Test Plan:
- Red only, red_data=7'b0000001: SDI sequence on SCLK rises is 0,1,0,0,0,0,0,0. CS is low 72 cycles, red_ack pulses once, busy falls 80 cycles after grant.
- Blue only, blue_data=7'b1000000: SDI sequence is 1,0,0,0,0,0,0,1. blue_ack pulses once and red_ack stays 0.
- Both requests raised in the same cycle after reset: red frame first, then blue frame. The CS-high gap between them is ≥CS_GAP+1 cycles.
- Both requests held for 4 frames: grants are R,B,R,B. Each ack pulses exactly twice.
- rst_n pulsed low at bit 4 of a frame: CS=1 and SCLK=0 immediately, no ack. After release, the pending request is re-arbitrated and completes a full 8-bit frame.
- SPI_LED_READBACK_EN defined, SDO driven 8'hA5 LSB first: rx_data=8'hA5 with rx_valid coincident with ack.
